// File: rtl/draw_points.sv
// draw_points: overlays the level's collectible points (blinking squares, capture flash)
// on the VGA pixel stream with a fixed 2-clk latency on every output.
module draw_points #(
  parameter int          POINT_W      = 20,
  parameter int          POINT_H      = 20,
  parameter int          BLINK_FRAMES = 16,
  parameter int          FLASH_FRAMES = 8,
  parameter logic [11:0] COLOR_A      = 12'hFF0,
  parameter logic [11:0] COLOR_B      = 12'hF80,
  parameter logic [11:0] FLASH_COLOR  = 12'hFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  input  logic [2:0]  lvl,
  input  logic [4:0]  captured,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out
);
  localparam logic [10:0] PX [5] = '{11'd265, 11'd515, 11'd235, 11'd310, 11'd400};
  localparam logic [10:0] PY [5] = '{11'd220, 11'd120, 11'd500, 11'd460, 11'd550};
  localparam logic [10:0] PW = 11'(POINT_W);
  localparam logic [10:0] PH = 11'(POINT_H);
  localparam logic [7:0]  BL = 8'(BLINK_FRAMES - 1);
  localparam logic [3:0]  FL = 4'(FLASH_FRAMES);

  logic [10:0] r_hcount1, r_vcount1;
  logic        r_hsync1, r_vsync1, r_hblnk1, r_vblnk1, r_blank1;
  logic [11:0] r_rgb1;
  logic [4:0]  r_hit, w_hit;
  logic        r_vsync_d, r_phase;
  logic [4:0]  r_cap_d;
  logic [2:0]  r_lvl_d;
  logic [7:0]  r_blink;
  logic [3:0]  r_flash [5];
  logic        w_tick, w_lvl_chg;
  logic [11:0] w_rgb;

  assign w_tick    = vsync_in && !r_vsync_d;
  assign w_lvl_chg = lvl != r_lvl_d;

  // subtract-then-compare keeps every operand at 11 bits
  always_comb begin
    w_hit = '0;
    for (int i = 0; i < 5; i++)
      w_hit[i] = (lvl == 3'b001) && (hcount_in >= PX[i]) && ((hcount_in - PX[i]) < PW)
                 && (vcount_in >= PY[i]) && ((vcount_in - PY[i]) < PH);
  end

  // walk from the highest index down so the lowest hit point decides
  always_comb begin
    w_rgb = r_rgb1;
    for (int i = 4; i >= 0; i--)
      if (r_hit[i] && r_flash[i] != '0) w_rgb = FLASH_COLOR;
      else if (r_hit[i] && !r_cap_d[i]) w_rgb = r_phase ? COLOR_B : COLOR_A;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hcount1 <= '0;
      r_vcount1 <= '0;
      r_hsync1  <= 1'b0;
      r_vsync1  <= 1'b0;
      r_hblnk1  <= 1'b0;
      r_vblnk1  <= 1'b0;
      r_blank1  <= 1'b0;
      r_rgb1    <= '0;
      r_hit     <= '0;
    end else begin
      r_hcount1 <= hcount_in;
      r_vcount1 <= vcount_in;
      r_hsync1  <= hsync_in;
      r_vsync1  <= vsync_in;
      r_hblnk1  <= hblnk_in;
      r_vblnk1  <= vblnk_in;
      r_blank1  <= hblnk_in || vblnk_in;
      r_rgb1    <= rgb_in;
      r_hit     <= w_hit;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vsync_d <= 1'b0;
      r_cap_d   <= '0;
      r_lvl_d   <= '0;
      r_blink   <= '0;
      r_phase   <= 1'b0;
      for (int i = 0; i < 5; i++) r_flash[i] <= '0;
    end else begin
      r_vsync_d <= vsync_in;
      r_cap_d   <= captured;
      r_lvl_d   <= lvl;
      if (w_tick) begin
        r_blink <= (r_blink == BL) ? 8'd0 : r_blink + 8'd1;
        r_phase <= (r_blink == BL) ? !r_phase : r_phase;
      end
      // a fresh capture loads even on a frame tick; release or level change wipes the flash
      for (int i = 0; i < 5; i++)
        if (captured[i] && !r_cap_d[i]) r_flash[i] <= FL;
        else if (w_lvl_chg || (!captured[i] && r_cap_d[i])) r_flash[i] <= '0;
        else if (w_tick && r_flash[i] != '0) r_flash[i] <= r_flash[i] - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcount_out <= '0;
      vcount_out <= '0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= '0;
    end else begin
      hcount_out <= r_hcount1;
      vcount_out <= r_vcount1;
      hsync_out  <= r_hsync1;
      vsync_out  <= r_vsync1;
      hblnk_out  <= r_hblnk1;
      vblnk_out  <= r_vblnk1;
      rgb_out    <= r_blank1 ? 12'h000 : w_rgb;
    end
  end
endmodule

// File: tb/tb_draw_points.sv
// tb_draw_points: randomized self-checking bench for draw_points against a
// frame-counting reference model (blink phase and flash life derived from frame numbers).
module tb_draw_points;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] hcount_in = '0, vcount_in = '0;
  logic        hsync_in = 1'b0, vsync_in = 1'b0, hblnk_in = 1'b0, vblnk_in = 1'b0;
  logic [11:0] rgb_in = '0;
  logic [2:0]  lvl = '0;
  logic [4:0]  captured = '0;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_out;

  int n_checks = 0;
  int n_fail = 0;

  draw_points dut (
    .clk(clk), .rst_n(rst_n),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .lvl(lvl), .captured(captured),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out),
    .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out)
  );

  always #5 clk = ~clk;

  // Reference model: frames = vsync rising edges since reset; a capture is
  // remembered by the frame number its flash starts in.
  int px [5] = '{265, 515, 235, 310, 400};
  int py [5] = '{220, 120, 500, 460, 550};
  int frames;
  bit prev_vs;
  bit fv [5];
  int cf [5];

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      frames  <= 0;
      prev_vs <= 1'b0;
    end else begin
      if (vsync_in && !prev_vs) frames <= frames + 1;
      prev_vs <= vsync_in;
    end

  function automatic logic [11:0] exp_rgb();
    int x, y;
    x = int'(hcount_in);
    y = int'(vcount_in);
    if (hblnk_in || vblnk_in) return 12'h000;
    if (lvl == 3'b001)
      for (int i = 0; i < 5; i++)
        if (x >= px[i] && x < px[i] + 20 && y >= py[i] && y < py[i] + 20) begin
          if (fv[i] && frames - cf[i] < 8) return 12'hFFF;
          if (!captured[i]) return ((frames / 16) % 2 == 1) ? 12'hF80 : 12'hFF0;
        end
    return rgb_in;
  endfunction

  task automatic tick_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic vpulse(int n);
    repeat (n) begin
      vsync_in = 1'b1;
      tick_clk();
      vsync_in = 1'b0;
      tick_clk();
    end
  endtask

  task automatic set_cap(logic [4:0] c, bit with_v);
    for (int i = 0; i < 5; i++) begin
      if (c[i] && !captured[i]) begin
        fv[i] = 1'b1;
        cf[i] = frames + ((with_v && !vsync_in) ? 1 : 0);
      end
      if (!c[i] && captured[i]) fv[i] = 1'b0;
    end
    captured = c;
    if (with_v) vsync_in = 1'b1;
    tick_clk();
    vsync_in = 1'b0;
    tick_clk();
  endtask

  task automatic set_lvl(logic [2:0] l);
    if (l != lvl) for (int i = 0; i < 5; i++) fv[i] = 1'b0;
    lvl = l;
    tick_clk();
  endtask

  task automatic check_px(string name, int h, int v);
    logic [11:0] e;
    hcount_in = 11'(h);
    vcount_in = 11'(v);
    rgb_in    = 12'($urandom);
    repeat (3) tick_clk();
    e = exp_rgb();
    n_checks++;
    if (rgb_out !== e) begin
      n_fail++;
      $display("FAIL %s (%0d,%0d): rgb_out=%h expected %h", name, h, v, rgb_out, e);
    end
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if ({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out} !== 51'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0",
               {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out});
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick_clk();
  endtask

  task automatic test_points();
    set_lvl(3'b001);
    check_px("p1_inside", 270, 225);
    check_px("p1_left_of", 264, 225);
    check_px("p1_top_left", 265, 220);
    check_px("p1_bottom_right", 284, 239);
    check_px("p1_right_edge", 285, 225);
    check_px("p1_below", 270, 240);
    check_px("p5_corner", 419, 569);
    check_px("p3_inside", 240, 505);
  endtask

  task automatic test_blink();
    vpulse(16);
    check_px("blink_p1_phase1", 270, 225);
    check_px("blink_p2_phase1", 520, 125);
    vpulse(15);
    check_px("blink_p1_before_toggle", 270, 225);
    vpulse(1);
    check_px("blink_p1_phase0", 270, 225);
  endtask

  task automatic test_flash();
    set_cap(5'b00001, 1'b0);
    check_px("flash_p1_start", 270, 225);
    check_px("flash_p2_blinks", 520, 125);
    vpulse(7);
    check_px("flash_p1_frame7", 270, 225);
    vpulse(1);
    check_px("flash_p1_gone", 270, 225);
    check_px("flash_p2_after", 520, 125);
  endtask

  task automatic test_coincide();
    set_cap(5'b00000, 1'b0);
    set_cap(5'b00011, 1'b1);
    vpulse(7);
    check_px("coinc_p1_frame7", 270, 225);
    check_px("coinc_p2_frame7", 520, 125);
    vpulse(1);
    check_px("coinc_p1_gone", 270, 225);
    set_cap(5'b00000, 1'b0);
    set_cap(5'b00011, 1'b0);
    vpulse(2);
    check_px("midflash_p1", 270, 225);
    set_cap(5'b00000, 1'b0);
    check_px("release_p1_blink", 270, 225);
    check_px("release_p2_blink", 520, 125);
  endtask

  task automatic test_lvl_delay();
    logic [37:0] hist [40];
    logic [37:0] e;
    set_cap(5'b00001, 1'b0);
    set_lvl(3'b010);
    check_px("lvl2_p1_pass", 270, 225);
    check_px("lvl2_p4_pass", 315, 465);
    for (int k = 0; k < 40; k++) begin
      hist[k] = 38'({$urandom, $urandom});
      {hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in, rgb_in} = hist[k];
      tick_clk();
      if (k >= 1) begin
        e = hist[k-1];
        if (e[13] || e[12]) e[11:0] = 12'h000;
        n_checks++;
        if ({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out} !== e) begin
          n_fail++;
          $display("FAIL delay2_cycle%0d: got %h expected %h", k,
                   {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out}, e);
        end
      end
    end
    {hsync_in, vsync_in, hblnk_in, vblnk_in} = 4'b0000;
    tick_clk();
    set_lvl(3'b001);
    check_px("lvl1_p1_no_flash", 270, 225);
    hblnk_in = 1'b1;
    check_px("hblnk_p1", 270, 225);
    hblnk_in = 1'b0;
    vblnk_in = 1'b1;
    check_px("vblnk_p1", 270, 225);
    vblnk_in = 1'b0;
    set_cap(5'b00000, 1'b0);
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    while ((frames / 16) % 2 == 0 && guard < 40) begin
      vpulse(1);
      guard++;
    end
    check_px("pre_reset_phase1", 270, 225);
    #2;
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) fv[i] = 1'b0;
    #1;
    n_checks++;
    if ({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out} !== 51'd0) begin
      n_fail++;
      $display("FAIL async_reset: got %h expected 0",
               {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick_clk();
    n_checks++;
    if ({hcount_out, rgb_out} !== 23'd0) begin
      n_fail++;
      $display("FAIL refill_clk1: got hcount=%0d rgb=%h expected 0/000", hcount_out, rgb_out);
    end
    tick_clk();
    n_checks++;
    if (hcount_out !== 11'd270 || rgb_out !== exp_rgb()) begin
      n_fail++;
      $display("FAIL refill_clk2: got hcount=%0d rgb=%h expected 270/%h", hcount_out, rgb_out, exp_rgb());
    end
    check_px("post_reset_p1", 270, 225);
  endtask

  initial begin
    for (int i = 0; i < 5; i++) begin
      fv[i] = 1'b0;
      cf[i] = 0;
    end
    test_reset();
    test_points();
    test_blink();
    test_flash();
    test_coincide();
    test_lvl_delay();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
